sr_latch_driver: RTL
====================

# sr_latch_driver

Clocked initiator for the team's asynchronous SR latch: accepts set/reset commands over a valid/ready handshake and drives the latch's `s`/`r` inputs with fixed-width, mutually exclusive pulses. It then checks the latch's `q`/`qbar` feedback through a synchronizer and reports completion or timeout. It sits between synchronous control logic and the SR latch cell.

## Interface
- `PULSE_CYCLES`, default 4: width of each `s`/`r` pulse in clock cycles; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles spent waiting for feedback to confirm; must be ≥ 1.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: command request.
- `req_val` in 1: requested latch value; 1 = set, 0 = reset.
- `req_ready` out 1: driver idle, so a command can be accepted.
- `s` out 1: set pulse to the latch.
- `r` out 1: reset pulse to the latch.
- `q` in 1: latch output, asynchronous to `clk`.
- `qbar` in 1: latch complement output, asynchronous to `clk`.
- `done` out 1: one-cycle completion strobe.
- `err` out 1: valid only with `done`; 1 = feedback failed to confirm before timeout.
- `state_q` out 1: last confirmed latch value, synchronized to `clk`.

## Operation
- Feedback path: `q` and `qbar` each pass through a two-flop synchronizer.
  - A synchronized pair "matches" when `q_s == val` and `qbar_s == ~val`.
  - `q_s == qbar_s` is an invalid pair and never matches.
- FSM states:
  - IDLE: `req_ready` = 1; `s` = `r` = 0. On `req_valid && req_ready`, capture `req_val`, load the counter with `PULSE_CYCLES-1`, go to PULSE.
  - PULSE: `s` = val, `r` = ~val. Decrement the counter. At 0, load the counter with `TIMEOUT_CYCLES-1` and go to CHECK.
  - CHECK: `s` = `r` = 0.
    - On match: go to IDLE with `done` = 1, `err` = 0; `state_q` ← val.
    - Otherwise, at counter 0: go to IDLE with `done` = 1, `err` = 1; `state_q` unchanged.
    - Otherwise: decrement the counter.
- All outputs are registered. Invariant: `s && r` is never 1.
- Every accepted command pulses the latch, even if the latch already holds the requested value.
- `req_val` is ignored when not accepted. `req_valid` asserted while busy is ignored; the requester holds it until accepted.
- Counter width is `$clog2(max(PULSE_CYCLES, TIMEOUT_CYCLES))`.

## Timing
- Reset values: `s` = `r` = 0, `done` = `err` = 0, `req_ready` = 1, `state_q` = 0, synchronizer flops 0, state IDLE.
- Reset takes effect immediately and asynchronously, including mid-PULSE.
  - `s`/`r` drop at once. The latch keeps whatever value it holds. No `done` is issued for the aborted command.
- Timeline, with acceptance edge e0:
  - `s`/`r` high for exactly `PULSE_CYCLES` cycles, e0 to e(P).
  - CHECK is evaluated at e(P+1) onward.
  - With an ideal latch and P ≥ 2, `done` is high in the cycle after e(P+1), i.e. `PULSE_CYCLES`+1 edges after acceptance.
  - Timeout: `done`/`err` are high in the cycle after e(P+TIMEOUT_CYCLES).
- `req_ready` is low from e0 until the `done` cycle. It is high during the `done` cycle, so a back-to-back request is accepted at the edge closing the `done` cycle.

## Structure
- Package `sr_latch_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_PULSE`, `ST_CHECK`);
  - `DEF_PULSE_CYCLES` = 4;
  - `DEF_TIMEOUT_CYCLES` = 16.
- Sub-module `sync2`: a parameterized-width two-flop synchronizer with async active-high reset to 0. It is instantiated once, 2 bits wide, for `{q, qbar}`.
- Parameter legality is checked at elaboration.

## Test plan
- Bench wiring: a behavioral SR latch model on `s`/`r`/`q`/`qbar`; defaults P = 4, T = 16; an assertion that `!(s && r)` every cycle.
- Reset, then set (`req_val` = 1) → `s` high 4 cycles, `r` = 0; `done` = 1 and `err` = 0 5 edges after acceptance; `q` = 1, `state_q` = 1.
- Then reset (`req_val` = 0) → `r` high 4 cycles; `done` = 1, `err` = 0; `q` = 0, `state_q` = 0.
- Latch model forced `q` = 0, `qbar` = 1, set request → `done` = 1 and `err` = 1 20 edges after acceptance; `state_q` stays 0.
- Force `q` = `qbar` = 1 (invalid pair), reset request → `err` = 1 at timeout; `state_q` unchanged.
- `req_valid` held high across two commands (1 then 0) → second accepted at the edge closing the first `done` cycle; no extra acceptance while `req_ready` = 0.
- `rst` asserted in the 2nd PULSE cycle → `s` = 0 immediately; `req_ready` = 1; `done` = 0; the next command completes normally.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: shared states and default timing for the SR latch driver.
package sr_latch_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_CHECK} state_t;
   localparam int DEF_PULSE_CYCLES = 4;
   localparam int DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/sync2.sv
// sync2: parameterized-width two-flop synchronizer, async active-high reset to 0.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q <= '0;
      end else begin
         meta <= d;
         q <= meta;
      end
   end
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked set/reset pulse initiator for an asynchronous SR latch,
// confirming the result through synchronized q/qbar feedback with a timeout.
module sr_latch_driver
   import sr_latch_pkg::*;
#(
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_val,
   output logic req_ready,
   output logic s,
   output logic r,
   input  logic q,
   input  logic qbar,
   output logic done,
   output logic err,
   output logic state_q
);
   localparam int CW = $clog2(PULSE_CYCLES > TIMEOUT_CYCLES ? PULSE_CYCLES : TIMEOUT_CYCLES);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

   if (PULSE_CYCLES < 2) begin : g_bad_pulse
      $error("PULSE_CYCLES must be >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic val, val_n, state_q_n, done_n, err_n, match;
   logic [1:0] fb;

   sync2 #(.W(2)) u_sync (.clk(clk), .rst(rst), .d({q, qbar}), .q(fb));

   // An invalid pair (q_s == qbar_s) can never satisfy both terms.
   assign match = (fb[1] == val) && (fb[0] == ~val);

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      val_n = val;
      state_q_n = state_q;
      done_n = 1'b0;
      err_n = 1'b0;
      case (state)
         ST_IDLE: if (req_valid) begin
            state_n = ST_PULSE;
            val_n = req_val;
            cnt_n = PULSE_LOAD;
         end
         ST_PULSE: if (cnt == '0) begin
            state_n = ST_CHECK;
            cnt_n = TIMEOUT_LOAD;
         end else cnt_n = cnt - 1'b1;
         ST_CHECK: if (match) begin
            state_n = ST_IDLE;
            done_n = 1'b1;
            state_q_n = val;
         end else if (cnt == '0) begin
            state_n = ST_IDLE;
            done_n = 1'b1;
            err_n = 1'b1;
         end else cnt_n = cnt - 1'b1;
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state so s/r track the pulse window exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt <= '0;
         val <= 1'b0;
         state_q <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         s <= 1'b0;
         r <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         val <= val_n;
         state_q <= state_q_n;
         done <= done_n;
         err <= err_n;
         s <= (state_n == ST_PULSE) && val_n;
         r <= (state_n == ST_PULSE) && !val_n;
         req_ready <= state_n == ST_IDLE;
      end
   end
endmodule
